// File: rtl/maint_scheduler.sv
// maint_scheduler: periodic maintenance scheduler for the DRAM-Bender frontend.
//
// Three interval timers (refresh, ZQ calibration, periodic read) accumulate
// pending maintenance work. One request at a time is presented over a
// req/ack/done handshake with fixed priority REF > ZQ > RD. Refreshes may be
// postponed up to MAX_POSTPONE; at that limit maint_urgent lets a REF through
// even while the host is busy.
//
// Configuration macro: MAINT_PER_RD_EN
//   defined   - periodic read timer and rd_pend flag present, type 2 issued
//   undefined - no RD logic, maint_type never equals 2, RD_INTERVAL ignored
//
// Ports:
//   clk                  single clock
//   rst                  asynchronous active-high reset
//   init_calib_complete  timers run only while high
//   busy                 host program running; holds off non-urgent requests
//   aref_en/_valid       auto-refresh enable value and its load strobe
//   maint_req/_type      request pending / kind (0 REF, 1 ZQ, 2 RD)
//   maint_urgent         pending_ref has reached MAX_POSTPONE
//   maint_ack/_done      frontend accepted / finished the request
//   pending_ref          refreshes owed
//   ref_overflow         sticky: a refresh was lost
module maint_scheduler #(
    parameter int unsigned REF_INTERVAL = 1950,
    parameter int unsigned ZQ_INTERVAL  = 25000000,
    parameter int unsigned RD_INTERVAL  = 250000,
    parameter int unsigned MAX_POSTPONE = 8,
    parameter int unsigned CTR_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_calib_complete,
    input  logic       busy,
    input  logic       aref_en,
    input  logic       aref_en_valid,
    output logic       maint_req,
    output logic [1:0] maint_type,
    output logic       maint_urgent,
    input  logic       maint_ack,
    input  logic       maint_done,
    output logic [3:0] pending_ref,
    output logic       ref_overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    localparam logic [1:0] TYPE_REF = 2'd0;
    localparam logic [1:0] TYPE_ZQ  = 2'd1;
    localparam logic [1:0] TYPE_RD  = 2'd2;
    localparam logic [3:0] MAX_P    = 4'(MAX_POSTPONE);

    // Elaboration-time parameter range checks.
    if (REF_INTERVAL == 0 || (64'(REF_INTERVAL) >> CTR_W) != 64'd0) begin : g_bad_ref
        $error("REF_INTERVAL must be in 1..2^CTR_W-1");
    end
    if (ZQ_INTERVAL == 0 || (64'(ZQ_INTERVAL) >> CTR_W) != 64'd0) begin : g_bad_zq
        $error("ZQ_INTERVAL must be in 1..2^CTR_W-1");
    end
    if (RD_INTERVAL == 0 || (64'(RD_INTERVAL) >> CTR_W) != 64'd0) begin : g_bad_rd
        $error("RD_INTERVAL must be in 1..2^CTR_W-1");
    end
    if (MAX_POSTPONE < 1 || MAX_POSTPONE > 15) begin : g_bad_max
        $error("MAX_POSTPONE must be in 1..15");
    end

    state_t           state;
    logic             ref_enable;
    logic [CTR_W-1:0] ref_cnt;
    logic [CTR_W-1:0] zq_cnt;
    logic             ref_exp;
    logic             zq_exp;
    logic             zq_pend;
    logic             rd_pend;

    // Interval timers: expiry is a registered one-cycle pulse.
    // The refresh timer is also held at 0 while auto-refresh is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            ref_exp <= 1'b0;
        end else if (!init_calib_complete || !ref_enable) begin
            ref_cnt <= '0;
            ref_exp <= 1'b0;
        end else if (ref_cnt == CTR_W'(REF_INTERVAL - 1)) begin
            ref_cnt <= '0;
            ref_exp <= 1'b1;
        end else begin
            ref_cnt <= ref_cnt + CTR_W'(1);
            ref_exp <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zq_cnt <= '0;
            zq_exp <= 1'b0;
        end else if (!init_calib_complete) begin
            zq_cnt <= '0;
            zq_exp <= 1'b0;
        end else if (zq_cnt == CTR_W'(ZQ_INTERVAL - 1)) begin
            zq_cnt <= '0;
            zq_exp <= 1'b1;
        end else begin
            zq_cnt <= zq_cnt + CTR_W'(1);
            zq_exp <= 1'b0;
        end
    end

    logic ack_fire;
    logic take_ref;
    logic take_zq;
    assign ack_fire = (state == ST_REQ) && maint_ack;
    assign take_ref = ack_fire && (maint_type == TYPE_REF);
    assign take_zq  = ack_fire && (maint_type == TYPE_ZQ);

`ifdef MAINT_PER_RD_EN
    logic [CTR_W-1:0] rd_cnt;
    logic             rd_exp;
    logic             take_rd;
    assign take_rd = ack_fire && (maint_type == TYPE_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            rd_exp <= 1'b0;
        end else if (!init_calib_complete) begin
            rd_cnt <= '0;
            rd_exp <= 1'b0;
        end else if (rd_cnt == CTR_W'(RD_INTERVAL - 1)) begin
            rd_cnt <= '0;
            rd_exp <= 1'b1;
        end else begin
            rd_cnt <= rd_cnt + CTR_W'(1);
            rd_exp <= 1'b0;
        end
    end

    // A new expiry wins over a same-cycle consume so no request is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rd_pend <= 1'b0;
        else if (rd_exp)  rd_pend <= 1'b1;
        else if (take_rd) rd_pend <= 1'b0;
    end
`else
    assign rd_pend = 1'b0;
`endif

    // Refresh bookkeeping. Increment is gated by ref_enable so an expiry
    // already in flight when refresh is disabled is dropped; decrement
    // saturates at 0 for a REF acked after the count was cleared.
    logic       ref_inc;
    logic       ref_dec;
    logic [3:0] pend_nxt;
    logic       ovf_set;
    assign ref_inc = ref_exp && ref_enable;
    assign ref_dec = take_ref && (pending_ref != 4'd0);

    always_comb begin
        pend_nxt = pending_ref;
        ovf_set  = 1'b0;
        if (aref_en_valid && !aref_en) begin
            pend_nxt = 4'd0;
        end else if (ref_inc && !ref_dec) begin
            if (pending_ref == MAX_P) ovf_set  = 1'b1;
            else                      pend_nxt = pending_ref + 4'd1;
        end else if (!ref_inc && ref_dec) begin
            pend_nxt = pending_ref - 4'd1;
        end
    end

    // Request selection; while busy, only an urgent REF is eligible.
    logic       sel_valid;
    logic [1:0] sel_type;
    always_comb begin
        sel_valid = 1'b0;
        sel_type  = TYPE_REF;
        if (pending_ref != 4'd0 && (!busy || maint_urgent)) begin
            sel_valid = 1'b1;
        end else if (!busy && zq_pend) begin
            sel_valid = 1'b1;
            sel_type  = TYPE_ZQ;
        end else if (!busy && rd_pend) begin
            sel_valid = 1'b1;
            sel_type  = TYPE_RD;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ref_enable   <= 1'b1;
            pending_ref  <= 4'd0;
            maint_urgent <= 1'b0;
            ref_overflow <= 1'b0;
            zq_pend      <= 1'b0;
            maint_req    <= 1'b0;
            maint_type   <= TYPE_REF;
        end else begin
            if (aref_en_valid) ref_enable <= aref_en;
            pending_ref  <= pend_nxt;
            maint_urgent <= (pend_nxt == MAX_P);
            if (ovf_set) ref_overflow <= 1'b1;

            if (zq_exp)       zq_pend <= 1'b1;
            else if (take_zq) zq_pend <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state      <= ST_REQ;
                        maint_req  <= 1'b1;
                        maint_type <= sel_type;
                    end
                end
                ST_REQ: begin
                    if (maint_ack) begin
                        state     <= ST_SERVICE;
                        maint_req <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (maint_done) state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    maint_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maint_scheduler.sv
// Testbench for maint_scheduler with REF_INTERVAL=16, ZQ_INTERVAL=100,
// RD_INTERVAL=40, MAX_POSTPONE=4. Expected request kinds are queued by the
// stimulus; a negedge monitor pops one on every rising maint_req.
// Cycle numbers below count posedges since init_calib_complete went high.
module tb_maint_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       icc = 1'b0;
    logic       busy = 1'b0;
    logic       aref_en = 1'b1;
    logic       aref_en_valid = 1'b0;
    logic       maint_ack = 1'b0;
    logic       maint_done = 1'b0;
    logic       maint_req;
    logic [1:0] maint_type;
    logic       maint_urgent;
    logic [3:0] pending_ref;
    logic       ref_overflow;

    maint_scheduler #(
        .REF_INTERVAL(16),
        .ZQ_INTERVAL (100),
        .RD_INTERVAL (40),
        .MAX_POSTPONE(4),
        .CTR_W       (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .init_calib_complete(icc),
        .busy               (busy),
        .aref_en            (aref_en),
        .aref_en_valid      (aref_en_valid),
        .maint_req          (maint_req),
        .maint_type         (maint_type),
        .maint_urgent       (maint_urgent),
        .maint_ack          (maint_ack),
        .maint_done         (maint_done),
        .pending_ref        (pending_ref),
        .ref_overflow       (ref_overflow)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    logic       req_prev = 1'b0;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (maint_req && !req_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected got type %0d want no request", maint_type);
            end else begin
                mon_exp = exp_q.pop_front();
                if (maint_type !== mon_exp) begin
                    errors++;
                    $display("FAIL req_type got %0d want %0d", maint_type, mon_exp);
                end
            end
        end
        req_prev = maint_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        icc = 1'b0;
        busy = 1'b0;
        maint_ack = 1'b0;
        maint_done = 1'b0;
        aref_en = 1'b1;
        aref_en_valid = 1'b0;
        exp_q.delete();
        repeat (2) tick();
    endtask

    task automatic start_run(input logic b);
        rst = 1'b0;
        icc = 1'b1;
        busy = b;
        cyc = 0;
    endtask

    // Queue the expected kind, wait for the request, ack it, optionally finish.
    task automatic serve(input logic [1:0] t, input int done_dly, input bit finish);
        bit ok;
        ok = 1'b0;
        exp_q.push_back(t);
        for (int i = 0; i < 300; i++) begin
            if (maint_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout got no request want type %0d", t);
            return;
        end
        maint_ack = 1'b1;
        tick();
        maint_ack = 1'b0;
        chk("req_drop_after_ack", int'(maint_req), 0);
        if (finish) begin
            repeat (done_dly) tick();
            maint_done = 1'b1;
            tick();
            maint_done = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_req", int'(maint_req), 0);
        chk("rst_type", int'(maint_type), 0);
        chk("rst_urgent", int'(maint_urgent), 0);
        chk("rst_pending", int'(pending_ref), 0);
        chk("rst_overflow", int'(ref_overflow), 0);

        // Basic refresh: expiry at 16, count at 17, request at 18
        start_run(1'b0);
        exp_q.push_back(2'd0);
        tick_to(17);
        chk("basic_pending_inc", int'(pending_ref), 1);
        chk("basic_req_not_yet", int'(maint_req), 0);
        tick_to(18);
        chk("basic_req", int'(maint_req), 1);
        chk("basic_type", int'(maint_type), 0);
        maint_ack = 1'b1;
        tick();
        maint_ack = 1'b0;
        chk("basic_req_after_ack", int'(maint_req), 0);
        chk("basic_pending_after_ack", int'(pending_ref), 0);
        repeat (4) tick();
        maint_done = 1'b1;
        tick();
        maint_done = 1'b0;
        tick_to(30);
        chk("basic_idle_no_req", int'(maint_req), 0);
        chk("basic_pending_end", int'(pending_ref), 0);

        // Postponement and urgency under busy
        do_reset();
        start_run(1'b1);
        exp_q.push_back(2'd0);
        tick_to(64);
        chk("post_pending3", int'(pending_ref), 3);
        chk("post_not_urgent", int'(maint_urgent), 0);
        chk("post_busy_hold", int'(maint_req), 0);
        tick_to(65);
        chk("post_pending4", int'(pending_ref), 4);
        chk("post_urgent", int'(maint_urgent), 1);
        tick_to(66);
        chk("post_urgent_req", int'(maint_req), 1);
        tick_to(80);
        chk("post_no_overflow_yet", int'(ref_overflow), 0);
        tick_to(81);
        chk("post_overflow", int'(ref_overflow), 1);
        chk("post_pending_sat", int'(pending_ref), 4);
        maint_ack = 1'b1;
        tick();
        maint_ack = 1'b0;
        chk("post_pending_dec", int'(pending_ref), 3);
        chk("post_urgent_clear", int'(maint_urgent), 0);
        chk("post_overflow_sticky", int'(ref_overflow), 1);
        // Asynchronous reset mid-SERVICE
        #2 rst = 1'b1;
        #1;
        chk("arst_pending", int'(pending_ref), 0);
        chk("arst_overflow", int'(ref_overflow), 0);
        chk("arst_req", int'(maint_req), 0);

        // Priority REF > ZQ > RD with all three pending at once
        do_reset();
        start_run(1'b1);
        aref_en = 1'b0;
        aref_en_valid = 1'b1;
        tick();
        aref_en_valid = 1'b0;
        tick_to(89);
        aref_en = 1'b1;
        aref_en_valid = 1'b1;
        tick();
        aref_en_valid = 1'b0;
        tick_to(106);
        chk("prio_pending0", int'(pending_ref), 0);
        tick_to(107);
        chk("prio_pending1", int'(pending_ref), 1);
        busy = 1'b0;
        serve(2'd0, 0, 1'b1);
        chk("prio_ref_taken", int'(pending_ref), 0);
`ifdef MAINT_PER_RD_EN
        serve(2'd1, 0, 1'b1);
        serve(2'd2, 0, 1'b0);
        chk("prio_type_in_service", int'(maint_type), 2);
`else
        serve(2'd1, 0, 1'b0);
        chk("prio_type_in_service", int'(maint_type), 1);
`endif
        // Asynchronous reset drops the in-flight request
        #2 rst = 1'b1;
        #1;
        chk("arst_type", int'(maint_type), 0);
        chk("arst_req2", int'(maint_req), 0);

        // Refresh expiry coinciding with REF ack
        do_reset();
        start_run(1'b1);
        exp_q.push_back(2'd0);
        tick_to(33);
        chk("coinc_pending2", int'(pending_ref), 2);
        busy = 1'b0;
        tick_to(34);
        chk("coinc_req", int'(maint_req), 1);
        tick_to(48);
        chk("coinc_pending_before", int'(pending_ref), 2);
        maint_ack = 1'b1;
        tick();
        maint_ack = 1'b0;
        chk("coinc_pending_same", int'(pending_ref), 2);
        chk("coinc_no_overflow", int'(ref_overflow), 0);
        maint_done = 1'b1;
        tick();
        maint_done = 1'b0;

        // Refresh disable clears the count; ZQ/RD continue
        do_reset();
        start_run(1'b1);
        tick_to(49);
        chk("dis_pending3", int'(pending_ref), 3);
        aref_en = 1'b0;
        aref_en_valid = 1'b1;
        tick();
        aref_en_valid = 1'b0;
        chk("dis_pending_clear", int'(pending_ref), 0);
        chk("dis_urgent", int'(maint_urgent), 0);
        busy = 1'b0;
`ifdef MAINT_PER_RD_EN
        serve(2'd2, 0, 1'b1);
        serve(2'd2, 0, 1'b1);
        serve(2'd1, 0, 1'b1);
        serve(2'd2, 0, 1'b1);
        serve(2'd2, 0, 1'b1);
        serve(2'd1, 0, 1'b1);
        serve(2'd2, 0, 1'b1);
        serve(2'd2, 0, 1'b1);
`else
        serve(2'd1, 0, 1'b1);
        serve(2'd1, 0, 1'b1);
`endif
        tick_to(250);
        chk("dis_no_req", int'(maint_req), 0);
        chk("dis_pending_end", int'(pending_ref), 0);
        chk("dis_overflow", int'(ref_overflow), 0);

        do_reset();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
